// File: rtl/item_stock_if.sv
// Request/status bundle between the keypad/payment front end and the stock controller.
// Handshake: vend/restock are level requests that are honoured only while busy is low, and one request produces one operation until both requests are released.
interface item_stock_if;
  logic [2:0] sel;
  logic       vend;
  logic       restock;
  logic [2:0] s;
  logic [3:0] count;
  logic       dispense;
  logic       sold_out;
  logic       busy;
  logic       all_empty;

  modport master (
    output sel, vend, restock,
    input  s, count, dispense, sold_out, busy, all_empty
  );

  modport slave (
    input  sel, vend, restock,
    output s, count, dispense, sold_out, busy, all_empty
  );
endinterface

// File: rtl/item_stock_ctrl.sv
// Vending machine item-count controller: eight 4-bit stock counts, the count mux
// select, and the vend/restock sequencing FSM with a timed dispense strobe.
module item_stock_ctrl #(
  parameter int INIT_COUNT  = 5,
  parameter int MAX_COUNT   = 9,
  parameter int DISP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  item_stock_if.slave bus,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOOKUP   = 3'd1;
  localparam logic [2:0] DISPENSE = 3'd2;
  localparam logic [2:0] RESTOCK  = 3'd3;
  localparam logic [2:0] HOLD     = 3'd4;

  localparam logic [3:0] INIT_LD = 4'(INIT_COUNT);
  localparam logic [3:0] MAX_LD  = 4'(MAX_COUNT);
  localparam logic [7:0] DISP_LD = 8'(DISP_CYCLES);

  logic [2:0] state_q, state_d;
  // s_q doubles as the latched slot: it only follows sel while idle.
  logic [2:0] s_q, s_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] cnt_q [8];
  logic [3:0] cnt_d [8];
  logic       all_empty_c;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        s_d = bus.sel;
        if (bus.restock) begin
          state_d = RESTOCK;
        end else if (bus.vend) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cnt_q[s_q] == 4'd0) begin
          state_d = HOLD;
        end else begin
          cnt_d[s_q] = cnt_q[s_q] - 4'd1;
          timer_d    = DISP_LD;
          state_d    = DISPENSE;
        end
      end
      DISPENSE: begin
        if (timer_q == 8'd1) begin
          state_d = HOLD;
        end else begin
          timer_d = timer_q - 8'd1;
        end
      end
      RESTOCK: begin
        cnt_d[s_q] = MAX_LD;
        state_d    = HOLD;
      end
      HOLD: begin
        if (!bus.vend && !bus.restock) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 3'd0;
      timer_q <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= INIT_LD;
      end
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    all_empty_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (cnt_q[i] != 4'd0) begin
        all_empty_c = 1'b0;
      end
    end
  end

  // Strobes decode straight from state_q so reset kills them without waiting for an edge.
  assign bus.s         = s_q;
  assign bus.count     = cnt_q[s_q];
  assign bus.dispense  = (state_q == DISPENSE);
  assign bus.sold_out  = (state_q == LOOKUP) && (cnt_q[s_q] == 4'd0);
  assign bus.busy      = (state_q != IDLE);
  assign bus.all_empty = all_empty_c;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_item_stock_ctrl.sv
// Randomized bench for item_stock_ctrl against a transaction-level stock model.
module tb_item_stock_ctrl;
  localparam int INIT = 5;
  localparam int MAXC = 9;
  localparam int DISP = 4;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;
  item_stock_if bus ();

  item_stock_ctrl #(.INIT_COUNT(INIT), .MAX_COUNT(MAXC), .DISP_CYCLES(DISP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         model [8];
  logic [3:0] exp_q [$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_empty();
    for (int i = 0; i < 8; i++) begin
      if (model[i] != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = INIT;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // driver + scoreboard for one request; hold = edges the request stays asserted
  task automatic do_op(input int sel, input bit v, input bit r, input int hold);
    int m_new, m_disp, m_min, m_so, m_busy;
    int disp_n, so_n, busy_n, pulses, first_disp, k, cnt_at2, s_at2;
    bit prev_d, done;
    logic [3:0] exp_v;
    m_new = model[sel]; m_disp = 0; m_so = 0; m_min = 2;
    if (r) begin
      m_new = MAXC;
    end else if (v) begin
      if (model[sel] == 0) m_so = 1;
      else begin
        m_new = model[sel] - 1; m_disp = DISP; m_min = DISP + 2;
      end
    end
    model[sel] = m_new;
    exp_q.push_back(4'(m_new));
    m_busy = (hold > m_min) ? hold : m_min;

    bus.sel = 3'(sel); bus.vend = v; bus.restock = r;
    disp_n = 0; so_n = 0; busy_n = 0; pulses = 0; first_disp = -1;
    k = 0; cnt_at2 = -1; s_at2 = -1; prev_d = 1'b0; done = 1'b0;
    while (!done && k < 200) begin
      tick();
      k++;
      if (k == 1) bus.sel = 3'($urandom_range(0, 7));
      if (k == hold) begin bus.vend = 1'b0; bus.restock = 1'b0; end
      if (bus.dispense) disp_n++;
      if (bus.dispense && !prev_d) pulses++;
      if (bus.dispense && first_disp < 0) first_disp = k;
      prev_d = bus.dispense;
      if (bus.sold_out) so_n++;
      if (k == 2) begin cnt_at2 = bus.count; s_at2 = bus.s; end
      if (bus.busy) busy_n++;
      else done = 1'b1;
    end
    exp_v = exp_q.pop_front();
    check("op_done", done, 1);
    check("dispense_cycles", disp_n, m_disp);
    check("dispense_pulses", pulses, (m_disp > 0) ? 1 : 0);
    check("dispense_start", first_disp, (m_disp > 0) ? 2 : -1);
    check("sold_out_cycles", so_n, m_so);
    check("busy_cycles", busy_n, m_busy);
    check("s_frozen", s_at2, sel);
    check("count_after_update", cnt_at2, exp_v);
    check("count_at_idle", bus.count, exp_v);
    check("all_empty", bus.all_empty, model_empty());
    bus.vend = 1'b0; bus.restock = 1'b0;
  endtask

  initial begin
    bus.sel = 3'd0; bus.vend = 1'b0; bus.restock = 1'b0;
    do_reset();
    check("rst_s", bus.s, 0);
    check("rst_count", bus.count, INIT);
    check("rst_all_empty", bus.all_empty, 0);
    check("rst_dispense", bus.dispense, 0);
    check("rst_sold_out", bus.sold_out, 0);
    check("rst_busy", bus.busy, 0);

    bus.sel = 3'd3;
    tick();
    check("idle_s_follows", bus.s, 3);
    check("idle_count", bus.count, INIT);

    do_op(2, 1, 0, 1);
    do_op(6, 1, 0, 20);
    do_op(6, 1, 0, 1);
    check("slot6_model", model[6], 3);
    for (int i = 0; i < 6; i++) do_op(0, 1, 0, 1);
    do_op(0, 0, 1, 1);
    do_op(5, 1, 1, 1);

    for (int n = 0; n < 40; n++) begin
      bit r;
      bit v;
      r = ($urandom_range(0, 3) == 0);
      v = r ? 1'($urandom_range(0, 1)) : 1'b1;
      do_op($urandom_range(0, 7), v, r, $urandom_range(1, 10));
      repeat ($urandom_range(0, 2)) begin
        bus.sel = 3'($urandom_range(0, 7));
        tick();
        check("idle_s_track", bus.s, bus.sel);
        check("idle_count_track", bus.count, model[bus.s]);
      end
    end

    // reset during the second dispense cycle
    bus.sel = 3'd1; bus.vend = 1'b1;
    tick();
    bus.vend = 1'b0;
    tick();
    check("mid_dispense_on", bus.dispense, 1);
    tick();
    #2 rst = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = INIT;
    #1;
    check("async_dispense_drop", bus.dispense, 0);
    check("async_busy_drop", bus.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.sel = 3'(i);
      tick();
      check("post_rst_count", bus.count, INIT);
    end

    for (int i = 0; i < 8; i++) begin
      while (model[i] > 0) do_op(i, 1, 0, $urandom_range(1, 3));
    end
    check("drained_all_empty", bus.all_empty, 1);
    do_op(4, 1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
